// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types, widths and 7-segment codes for the GCD display path.
package gcd_pkg;
  localparam int DATA_W = 8;
  localparam int BCD_W = 12;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_CODE[d];
  endfunction
endpackage

// File: rtl/gcd_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift per cycle, result valid while done.
module bin2bcd_seq
  import gcd_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [DATA_W-1:0] sr;
  logic [BCD_W-1:0] scr, adj;
  function automatic logic [3:0] fix(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  always_comb begin
    adj = {fix(scr[11:8]), fix(scr[7:4]), fix(scr[3:0])};
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == 3'd7 ? LATCH : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      scr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sr <= bin;
        scr <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {scr, sr} <= {adj, sr} << 1;
        cnt <= cnt + 3'd1;
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == LATCH;
  assign bcd = scr;
endmodule

// File: rtl/gcd_display.sv
// gcd_display: latches GCD results, converts to BCD and scans a 4-digit active-low display.
module gcd_display
  import gcd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] gcd_in,
  input  logic              gcd_vld,
  output logic              busy,
  output logic [BCD_W-1:0]  bcd,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              dp
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic pend_v, start, done, blank;
  logic [DATA_W-1:0] pend_val;
  logic [BCD_W-1:0] eng_bcd;
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic [3:0] digit, an_nx;
  logic [6:0] seg_nx;
  assign start = !busy && (gcd_vld || pend_v);
  bin2bcd_seq u_eng (
    .clk(clk), .clr(clr), .start(start), .bin(pend_v ? pend_val : gcd_in),
    .busy(busy), .done(done), .bcd(eng_bcd)
  );
  // a pending value is consumed first; a strobe in that same cycle refills pending
  always_ff @(posedge clk) begin
    if (clr) begin
      pend_v <= 1'b0;
      pend_val <= '0;
      bcd <= '0;
    end else begin
      if (gcd_vld && (busy || pend_v)) begin
        pend_v <= 1'b1;
        pend_val <= gcd_in;
      end else if (!busy && pend_v) pend_v <= 1'b0;
      if (done) bcd <= eng_bcd;
    end
  end
  always_comb begin
    digit = idx == 2'd0 ? bcd[3:0] : idx == 2'd1 ? bcd[7:4] : bcd[11:8];
    blank = idx == 2'd3 || (idx == 2'd2 && bcd[11:8] == 4'd0) ||
            (idx == 2'd1 && bcd[11:4] == 8'd0);
    an_nx = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_nx = blank ? SEG_BLANK : seg_of(digit);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      presc <= '0;
      idx <= '0;
      an <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      presc <= presc == PW'(REFRESH_DIV - 1) ? '0 : presc + 1'b1;
      if (presc == PW'(REFRESH_DIV - 1)) idx <= idx + 2'd1;
      an <= an_nx;
      seg <= seg_nx;
    end
  end
  assign dp = 1'b1;
endmodule

// File: tb/tb_gcd_display.sv
// tb_gcd_display: random and directed stimulus against an arithmetic reference model.
module tb_gcd_display;
  localparam int DIV = 4;
  logic clk = 0, clr = 0, gcd_vld = 0;
  logic [7:0] gcd_in = 0;
  logic busy, dp;
  logic [11:0] bcd;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0, failures = 0;
  gcd_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .clr(clr), .gcd_in(gcd_in), .gcd_vld(gcd_vld),
    .busy(busy), .bcd(bcd), .seg(seg), .an(an), .dp(dp)
  );
  always #5 clk = ~clk;
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int rem, num, job, presc, idx;
  bit pv, ok = 0, watch = 0;
  int pval;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [11:0] to_bcd(int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction
  always @(posedge clk) begin
    if (clr) begin
      rem = 0; num = 0; pv = 0; pval = 0; presc = 0; idx = 0;
      e_an = 4'b1110; e_seg = 7'b1000000; ok = 1;
    end else begin
      int h, t, o, d;
      bit blank, was_busy;
      h = num / 100; t = (num / 10) % 10; o = num % 10;
      blank = idx == 3 || (idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0);
      d = idx == 0 ? o : idx == 1 ? t : h;
      e_an = blank ? 4'b1111 : ~(4'b0001 << idx);
      e_seg = blank ? 7'b1111111 : segtab[d];
      if (presc == DIV - 1) begin presc = 0; idx = (idx + 1) % 4; end
      else presc++;
      was_busy = rem > 0;
      if (rem > 0) begin rem--; if (rem == 0) num = job; end
      if (!was_busy && (gcd_vld || pv)) begin job = pv ? pval : int'(gcd_in); rem = 9; end
      if (gcd_vld && (was_busy || pv)) begin pv = 1; pval = gcd_in; end
      else if (!was_busy && pv) pv = 0;
    end
  end
  always @(negedge clk) if (ok) begin
    chk("bcd", bcd, to_bcd(num));
    chk("busy", busy, rem > 0);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, 1);
    if (watch) chk("no_040", bcd == 12'h040, 0);
  end
  task automatic tick(int n); repeat (n) @(negedge clk); endtask
  task automatic pulse(logic [7:0] v);
    gcd_in = v; gcd_vld = 1; tick(1); gcd_vld = 0;
  endtask
  task automatic scan_count(logic [3:0] want, logic [6:0] want_seg, bit test_seg, int exp_n, string name);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (an == want) begin
        n++;
        if (test_seg) chk({name, "_seg"}, seg, want_seg);
      end
    end
    chk(name, n, exp_n);
  endtask
  initial begin
    clr = 1; tick(2); clr = 0;
    chk("rst_bcd", bcd, 12'h000); chk("rst_busy", busy, 0);
    chk("rst_an", an, 4'b1110); chk("rst_seg", seg, 7'b1000000); chk("rst_dp", dp, 1);
    pulse(8'd255);
    chk("busy_e0", busy, 1);
    tick(8); chk("busy_e8", busy, 1); chk("bcd_pre", bcd, 12'h000);
    tick(1); chk("bcd_255", bcd, 12'h255); chk("busy_e9", busy, 0);
    tick(2);
    scan_count(4'b1110, 7'b0010010, 1, 4, "slot_ones");
    scan_count(4'b1101, 7'b0010010, 1, 4, "slot_tens");
    scan_count(4'b1011, 7'b0100100, 1, 4, "slot_hund");
    scan_count(4'b1111, 7'b1111111, 1, 4, "slot_blank");
    pulse(8'd6); tick(9); chk("bcd_006", bcd, 12'h006);
    tick(2); scan_count(4'b1111, 7'b1111111, 1, 12, "blank_6");
    pulse(8'd100); tick(9); chk("bcd_100", bcd, 12'h100);
    tick(2); scan_count(4'b1101, 7'b1000000, 1, 4, "tens_zero_100");
    watch = 1;
    pulse(8'd12); tick(2); pulse(8'd40); tick(1); pulse(8'd7);
    tick(4); chk("pend_012", bcd, 12'h012);
    tick(10); chk("pend_007", bcd, 12'h007);
    tick(12); watch = 0;
    pulse(8'd99); tick(3); clr = 1; tick(1); clr = 0;
    tick(1); chk("abort_busy", busy, 0);
    tick(20); chk("abort_bcd", bcd, 12'h000);
    pulse(8'd21); tick(9); chk("after_abort", bcd, 12'h021);
    clr = 1; gcd_vld = 1; gcd_in = 8'd77; tick(1); clr = 0; gcd_vld = 0;
    chk("prio_busy", busy, 0); tick(12); chk("prio_bcd", bcd, 12'h000);
    for (int i = 0; i < 3000; i++) begin
      gcd_in = 8'($urandom);
      gcd_vld = $urandom_range(0, 5) == 0;
      clr = $urandom_range(0, 299) == 0;
      tick(1);
    end
    gcd_vld = 0; clr = 0; tick(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
